reminder_alert_ctrl: RTL and testbench



---
 rtl/reminder_pkg.sv | 33 +++
 rtl/switch_debounce.sv | 60 ++++++
 rtl/reminder_alert_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_reminder_alert_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reminder_pkg.sv
// -----------------------------------------------------------------------------
// reminder_pkg
// Shared types and constants for the reminder alert stage.
//   alert_state_e : alert FSM states (IDLE, BEEP_ON, BEEP_OFF, GAP)
//   *_DEF         : default timing for the 50 MHz internal clock
//   MISSED_MAX    : saturation value of the missed-alert counter
//   sat_inc8()    : saturating 8-bit increment
// -----------------------------------------------------------------------------
package reminder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BEEP_ON  = 2'd1,
    BEEP_OFF = 2'd2,
    GAP      = 2'd3
  } alert_state_e;

  localparam int TICK_DIV_DEF        = 50000;
  localparam int DEBOUNCE_MS_DEF     = 20;
  localparam int BEEP_ON_MS_DEF      = 200;
  localparam int BEEP_OFF_MS_DEF     = 300;
  localparam int BEEPS_PER_BURST_DEF = 3;
  localparam int BURST_GAP_MS_DEF    = 2000;
  localparam int MAX_BURSTS_DEF      = 5;

  localparam logic [7:0] MISSED_MAX = 8'hFF;

  // Counts up to MISSED_MAX and then holds; never wraps back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == MISSED_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
// Synchronizes a raw mechanical switch, filters bounce and emits a one-cycle
// pulse when the filtered level goes from released to pressed.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   sw   : raw asynchronous switch input (1 = pressed)
//   rise : one-cycle pulse one clock after the filtered level rises
// The filtered level only follows the synchronized input once the two have
// disagreed for STABLE_CYCLES consecutive clocks.
// -----------------------------------------------------------------------------
module switch_debounce #(
  parameter int STABLE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic rise
);

  localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register here is updated with <= so all right-hand sides see
  // the values from before the clock edge; blocking = would make the order of
  // statements change the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      rise    <= 1'b0;
    end else begin
      sync1   <= sw;
      sync2   <= sync1;
      level_d <= level;
      rise    <= level & ~level_d;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // Any agreement breaks the run; bounce restarts the stability window.
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/reminder_alert_ctrl.sv
// -----------------------------------------------------------------------------
// reminder_alert_ctrl
// Alert stage behind reminder_system: beeps a piezo in bursts while reminders
// are outstanding, until the user presses stop or the alert times out.
//   clk        : system clock (internal 50 MHz)
//   rst        : synchronous, active-high reset
//   remind_vec : one-hot reminder levels; rising bits are new reminders
//   stop_sw    : raw stop push-button (1 = pressed)
//   buzzer     : buzzer drive
//   alert_led  : reminders currently being alerted
//   ack        : one-cycle pulse when the user stops an active alert
//   missed     : one-cycle pulse when an alert times out
//   missed_cnt : number of timed-out alerts, saturating at 255
//   busy       : alert FSM not in IDLE
// -----------------------------------------------------------------------------
module reminder_alert_ctrl
  import reminder_pkg::*;
#(
  parameter int TICK_DIV        = TICK_DIV_DEF,
  parameter int DEBOUNCE_MS     = DEBOUNCE_MS_DEF,
  parameter int BEEP_ON_MS      = BEEP_ON_MS_DEF,
  parameter int BEEP_OFF_MS     = BEEP_OFF_MS_DEF,
  parameter int BEEPS_PER_BURST = BEEPS_PER_BURST_DEF,
  parameter int BURST_GAP_MS    = BURST_GAP_MS_DEF,
  parameter int MAX_BURSTS      = MAX_BURSTS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] remind_vec,
  input  logic       stop_sw,
  output logic       buzzer,
  output logic [7:0] alert_led,
  output logic       ack,
  output logic       missed,
  output logic [7:0] missed_cnt,
  output logic       busy
);

  localparam int               PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [11:0]      ON_LAST   = 12'(BEEP_ON_MS - 1);
  localparam logic [11:0]      OFF_LAST  = 12'(BEEP_OFF_MS - 1);
  localparam logic [11:0]      GAP_LAST  = 12'(BURST_GAP_MS - 1);
  localparam logic [3:0]       BEEPS_L   = 4'(BEEPS_PER_BURST);
  localparam logic [3:0]       BURSTS_L  = 4'(MAX_BURSTS);

  // ---------------------------------------------------------------------------
  // Stop switch
  // ---------------------------------------------------------------------------
  logic stop_evt;

  switch_debounce #(
    .STABLE_CYCLES(DEBOUNCE_MS * TICK_DIV)
  ) u_stop_db (
    .clk  (clk),
    .rst  (rst),
    .sw   (stop_sw),
    .rise (stop_evt)
  );

  // ---------------------------------------------------------------------------
  // Reminder edge detection. remind_vec is captured into remind_in first and
  // edges are taken between remind_in and its delayed copy remind_q, so a new
  // reminder reaches pending one clock after it is first sampled.
  // ---------------------------------------------------------------------------
  logic [7:0] remind_in;
  logic [7:0] remind_q;
  logic [7:0] new_bits;

  assign new_bits = remind_in & ~remind_q;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  alert_state_e     state,      state_n;
  logic [7:0]       pending,    pending_n;
  logic [7:0]       alert_n;
  logic [3:0]       beep_cnt,   beep_n;
  logic [3:0]       burst_cnt,  burst_n;
  logic [3:0]       burst_inc;
  logic [7:0]       missed_cnt_n;
  logic             ack_n;
  logic             missed_n;

  // ---------------------------------------------------------------------------
  // Millisecond prescaler and phase timer. Both restart on every state change
  // so each phase lasts an exact whole number of ticks.
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] pre_cnt;
  logic [11:0]      phase_ms;
  logic [11:0]      phase_last;
  logic             tick;
  logic             phase_done;

  assign tick       = (pre_cnt == PRE_LAST);
  assign phase_done = tick && (phase_ms == phase_last);

  always_ff @(posedge clk) begin
    if (rst || (state_n != state) || (state == IDLE)) begin
      pre_cnt  <= '0;
      phase_ms <= '0;
    end else if (tick) begin
      pre_cnt  <= '0;
      phase_ms <= phase_ms + 12'd1;
    end else begin
      pre_cnt  <= pre_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    state_n      = state;
    pending_n    = pending;
    alert_n      = alert_led;
    beep_n       = beep_cnt;
    burst_n      = burst_cnt;
    burst_inc    = burst_cnt + 4'd1;
    missed_cnt_n = missed_cnt;
    ack_n        = 1'b0;
    missed_n     = 1'b0;
    phase_last   = '0;

    case (state)
      BEEP_ON:  phase_last = ON_LAST;
      BEEP_OFF: phase_last = OFF_LAST;
      GAP:      phase_last = GAP_LAST;
      default:  phase_last = '0;
    endcase

    if (state == IDLE) begin
      if (pending != '0) begin
        // Reminders arriving in this same cycle join the alert being started.
        alert_n   = pending | new_bits;
        pending_n = '0;
        beep_n    = 4'd0;
        burst_n   = 4'd0;
        state_n   = BEEP_ON;
      end else begin
        pending_n = pending | new_bits;
      end
    end else if (stop_evt) begin
      // Stop beats both a coincident timeout and coincident new reminders;
      // the latter are parked in pending and start a fresh alert from IDLE.
      ack_n     = 1'b1;
      alert_n   = '0;
      pending_n = pending | new_bits;
      state_n   = IDLE;
    end else begin
      if (new_bits != '0) begin
        // Fresh reminders extend the alert without disturbing the beep phase.
        alert_n = alert_led | new_bits;
        burst_n = 4'd0;
      end
      burst_inc = burst_n + 4'd1;
      if (phase_done) begin
        case (state)
          BEEP_ON: begin
            state_n = BEEP_OFF;
          end
          BEEP_OFF: begin
            beep_n  = beep_cnt + 4'd1;
            state_n = (beep_n == BEEPS_L) ? GAP : BEEP_ON;
          end
          GAP: begin
            beep_n  = 4'd0;
            burst_n = burst_inc;
            if (burst_inc == BURSTS_L) begin
              missed_n     = 1'b1;
              missed_cnt_n = sat_inc8(missed_cnt);
              alert_n      = '0;
              state_n      = IDLE;
            end else begin
              state_n = BEEP_ON;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers; every output is driven straight from a flop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      remind_in  <= '0;
      remind_q   <= '0;
      state      <= IDLE;
      pending    <= '0;
      alert_led  <= '0;
      beep_cnt   <= '0;
      burst_cnt  <= '0;
      missed_cnt <= '0;
      ack        <= 1'b0;
      missed     <= 1'b0;
      buzzer     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      remind_in  <= remind_vec;
      remind_q   <= remind_in;
      state      <= state_n;
      pending    <= pending_n;
      alert_led  <= alert_n;
      beep_cnt   <= beep_n;
      burst_cnt  <= burst_n;
      missed_cnt <= missed_cnt_n;
      ack        <= ack_n;
      missed     <= missed_n;
      buzzer     <= (state_n == BEEP_ON);
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_reminder_alert_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reminder_alert_ctrl
// Directed bench for reminder_alert_ctrl with small timing parameters:
// TICK_DIV=4, DEBOUNCE_MS=2, BEEP_ON_MS=3, BEEP_OFF_MS=2, BEEPS_PER_BURST=2,
// BURST_GAP_MS=5, MAX_BURSTS=2. One burst = 12 on, 8 off, 12 on, 28 off
// (the last 20 being the gap) = 60 cycles; an unacknowledged alert ends
// 120 cycles after BEEP_ON is entered. Inputs are driven and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_reminder_alert_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] remind_vec;
  logic       stop_sw;
  logic       buzzer;
  logic [7:0] alert_led;
  logic       ack;
  logic       missed;
  logic [7:0] missed_cnt;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reminder_alert_ctrl #(
    .TICK_DIV        (4),
    .DEBOUNCE_MS     (2),
    .BEEP_ON_MS      (3),
    .BEEP_OFF_MS     (2),
    .BEEPS_PER_BURST (2),
    .BURST_GAP_MS    (5),
    .MAX_BURSTS      (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .remind_vec (remind_vec),
    .stop_sw    (stop_sw),
    .buzzer     (buzzer),
    .alert_led  (alert_led),
    .ack        (ack),
    .missed     (missed),
    .missed_cnt (missed_cnt),
    .busy       (busy)
  );

  // One row: at falling edge number s, compare the outputs, then apply inputs.
  typedef struct {
    int         s;
    logic [7:0] remind;
    logic       stop;
    logic       buzzer;
    logic [7:0] led;
    logic       busy;
    logic       ack;
    logic       missed;
    logic [7:0] mcnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int s, logic [7:0] r, logic st, logic bz, logic [7:0] led,
                              logic bsy, logic ak, logic ms, logic [7:0] mc);
    vec_t v;
    v.s = s; v.remind = r; v.stop = st; v.buzzer = bz; v.led = led;
    v.busy = bsy; v.ack = ak; v.missed = ms; v.mcnt = mc;
    return v;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst        = 1'b1;
    remind_vec = 8'h00;
    stop_sw    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic bz, input logic [7:0] led,
                           input logic bsy, input logic ak, input logic ms, input logic [7:0] mc);
    check({tag, ".buzzer"},     buzzer,     bz);
    check({tag, ".alert_led"},  alert_led,  led);
    check({tag, ".busy"},       busy,       bsy);
    check({tag, ".ack"},        ack,        ak);
    check({tag, ".missed"},     missed,     ms);
    check({tag, ".missed_cnt"}, missed_cnt, mc);
  endtask

  task automatic run_table(input string tag, input int last_s);
    int idx = 0;
    for (int s = 0; s <= last_s; s++) begin
      @(negedge clk);
      if (idx < tbl.size() && tbl[idx].s == s) begin
        check_all($sformatf("%s@%0d", tag, s), tbl[idx].buzzer, tbl[idx].led,
                  tbl[idx].busy, tbl[idx].ack, tbl[idx].missed, tbl[idx].mcnt);
        remind_vec = tbl[idx].remind;
        stop_sw    = tbl[idx].stop;
        idx++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_seen;
    int got;
    logic [0:4] bounce;

    rst        = 1'b1;
    remind_vec = 8'h00;
    stop_sw    = 1'b0;

    // ---- reset state ---------------------------------------------------------
    repeat (2) @(negedge clk);
    check_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);

    // ---- 1+2: full unacknowledged alert --------------------------------------
    // s=0 applies remind 01; BEEP_ON visible at s=3 (t = s-3 from BEEP_ON entry).
    reset_dut();
    tbl.delete();
    tbl.push_back(mk(  0, 8'h01, 0, 0, 8'h00, 0, 0, 0, 8'd0));
    tbl.push_back(mk(  2, 8'h01, 0, 0, 8'h00, 0, 0, 0, 8'd0));
    tbl.push_back(mk(  3, 8'h01, 0, 1, 8'h01, 1, 0, 0, 8'd0));
    tbl.push_back(mk( 14, 8'h01, 0, 1, 8'h01, 1, 0, 0, 8'd0));
    tbl.push_back(mk( 15, 8'h01, 0, 0, 8'h01, 1, 0, 0, 8'd0));
    tbl.push_back(mk( 22, 8'h01, 0, 0, 8'h01, 1, 0, 0, 8'd0));
    tbl.push_back(mk( 23, 8'h01, 0, 1, 8'h01, 1, 0, 0, 8'd0));
    tbl.push_back(mk( 34, 8'h01, 0, 1, 8'h01, 1, 0, 0, 8'd0));
    tbl.push_back(mk( 35, 8'h01, 0, 0, 8'h01, 1, 0, 0, 8'd0));
    tbl.push_back(mk( 62, 8'h01, 0, 0, 8'h01, 1, 0, 0, 8'd0));
    tbl.push_back(mk( 63, 8'h01, 0, 1, 8'h01, 1, 0, 0, 8'd0));
    tbl.push_back(mk(122, 8'h01, 0, 0, 8'h01, 1, 0, 0, 8'd0));
    tbl.push_back(mk(123, 8'h01, 0, 0, 8'h00, 0, 0, 1, 8'd1));
    tbl.push_back(mk(124, 8'h01, 0, 0, 8'h00, 0, 0, 0, 8'd1));
    run_table("timeout", 124);

    // ---- 4: new reminder during GAP of burst 2 restarts the burst count ------
    reset_dut();
    tbl.delete();
    tbl.push_back(mk(  0, 8'h01, 0, 0, 8'h00, 0, 0, 0, 8'd0));
    tbl.push_back(mk(  3, 8'h01, 0, 1, 8'h01, 1, 0, 0, 8'd0));
    tbl.push_back(mk(108, 8'h03, 0, 0, 8'h01, 1, 0, 0, 8'd0));
    tbl.push_back(mk(109, 8'h03, 0, 0, 8'h01, 1, 0, 0, 8'd0));
    tbl.push_back(mk(110, 8'h03, 0, 0, 8'h03, 1, 0, 0, 8'd0));
    tbl.push_back(mk(122, 8'h03, 0, 0, 8'h03, 1, 0, 0, 8'd0));
    tbl.push_back(mk(123, 8'h03, 0, 1, 8'h03, 1, 0, 0, 8'd0));
    tbl.push_back(mk(182, 8'h03, 0, 0, 8'h03, 1, 0, 0, 8'd0));
    tbl.push_back(mk(183, 8'h03, 0, 0, 8'h00, 0, 0, 1, 8'd1));
    tbl.push_back(mk(184, 8'h03, 0, 0, 8'h00, 0, 0, 0, 8'd1));
    run_table("extend", 184);

    // ---- 3: bouncing stop mid-BEEP_ON ----------------------------------------
    reset_dut();
    @(negedge clk);
    remind_vec = 8'h01;                       // s=0
    repeat (7) @(negedge clk);                // s=7, BEEP_ON t=4
    bounce = 5'b10110;
    for (int i = 0; i < 5; i++) begin
      stop_sw = bounce[i];
      @(negedge clk);
    end
    stop_sw = 1'b1;                           // stable from here (t=9)
    for (int j = 1; j <= 13; j++) begin
      @(negedge clk);
      check($sformatf("stop.ack@%0d", j), ack, (j == 12));
      if (j == 11) check("stop.buzzer_before", buzzer, 1'b1);
      if (j == 12) begin
        check("stop.buzzer",    buzzer,     1'b0);
        check("stop.alert_led", alert_led,  8'h00);
        check("stop.busy",      busy,       1'b0);
        check("stop.missed_cnt", missed_cnt, 8'd0);
      end
    end
    // Held, released and re-pressed in IDLE: no further ack, no timeout.
    ack_seen = 0;
    for (int j = 0; j < 160; j++) begin
      if (j == 130) stop_sw = 1'b0;
      if (j == 145) stop_sw = 1'b1;
      @(negedge clk);
      if (ack || missed) ack_seen++;
    end
    check("idle_stop.pulses", ack_seen, 0);
    check("idle_stop.busy", busy, 1'b0);
    check("idle_stop.missed_cnt", missed_cnt, 8'd0);

    // ---- 5: stop coincident with a new reminder ------------------------------
    reset_dut();
    @(negedge clk);
    remind_vec = 8'h01;                       // s=0
    repeat (5) @(negedge clk);                // in BEEP_ON
    stop_sw = 1'b1;                           // n
    repeat (10) @(negedge clk);
    remind_vec = 8'h04;                       // n+10: new bit meets stop_evt
    @(negedge clk);
    check("coinc.ack_early", ack, 1'b0);
    @(negedge clk);
    check_all("coinc.stop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0);
    @(negedge clk);
    check_all("coinc.restart", 1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 8'd0);

    // ---- 6: saturation of missed_cnt, then reset mid-BEEP_ON -----------------
    reset_dut();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      remind_vec = 8'h00;
      @(negedge clk);
      remind_vec = 8'h01;
      got = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (missed) begin
          got = 1;
          break;
        end
      end
      if (got == 0) begin
        check($sformatf("sat.missed_wait%0d", i), got, 1);
        break;
      end
      if (i == 0)   check("sat.cnt1",   missed_cnt, 8'd1);
      if (i == 253) check("sat.cnt254", missed_cnt, 8'd254);
      if (i == 254) check("sat.cnt255", missed_cnt, 8'd255);
      if (i == 255) check("sat.hold",   missed_cnt, 8'd255);
    end
    @(negedge clk);
    remind_vec = 8'h00;
    @(negedge clk);
    remind_vec = 8'h01;                       // s=0
    repeat (5) @(negedge clk);
    check("rst.pre_buzzer", buzzer, 1'b1);
    check("rst.pre_busy",   busy,   1'b1);
    rst        = 1'b1;
    remind_vec = 8'h00;
    @(negedge clk);
    check_all("rst.mid", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst.after_busy", busy, 1'b0);
    check("rst.after_led",  alert_led, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
